// File: rtl/cache_req_pkg.sv
// Shared types and constants for the cache request initiator.
// The FIFO record holds {write, tag, index, wdata}, MSB first.
package cache_req_pkg;

    localparam int INDEX_WIDTH = 6;
    localparam int COUNT_WIDTH = 16;
    localparam int CMD_WIDTH   = 1 + 8 + INDEX_WIDTH + 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_HOLD  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RESP  = 3'd4
    } state_e;

    function automatic int cmd_width(input int tag_w, input int data_w);
        return 1 + tag_w + INDEX_WIDTH + data_w;
    endfunction

    function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/cache_cmd_fifo.sv
// Synchronous FIFO for buffered cache commands; pointers carry an extra wrap bit
// so full and empty are distinguished without a separate occupancy counter.
module cache_cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push;
    logic             do_pop;

    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: nothing reads an entry before it is written.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/cache_req_master.sv
// Cache request initiator: buffers commands, drives two-cycle request strobes,
// and returns one response per command with timeout and hit/miss counters.
//   state | meaning
//   IDLE  | waiting for a buffered command; pops it into cmd_q
//   ISSUE | first strobe cycle
//   HOLD  | second strobe cycle; cache_hit sampled
//   WAIT  | strobes low; waiting for cache_ready or timeout
//   RESP  | response held until rsp_ready
module cache_req_master
    import cache_req_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_write,
    input  logic [TAG_WIDTH-1:0]   cmd_tag,
    input  logic [INDEX_WIDTH-1:0] cmd_index,
    input  logic [DATA_WIDTH-1:0]  cmd_wdata,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic                   rsp_write,
    output logic [DATA_WIDTH-1:0]  rsp_data,
    output logic                   rsp_hit,
    output logic                   rsp_error,
    output logic [TAG_WIDTH-1:0]   addr_tag,
    output logic [INDEX_WIDTH-1:0] addr_index,
    output logic [DATA_WIDTH-1:0]  write_data,
    output logic                   cache_read,
    output logic                   cache_write,
    input  logic [DATA_WIDTH-1:0]  read_data,
    input  logic                   cache_hit,
    input  logic                   cache_ready,
    output logic [COUNT_WIDTH-1:0] hit_count,
    output logic [COUNT_WIDTH-1:0] miss_count
);

    localparam int CW    = cmd_width(TAG_WIDTH, DATA_WIDTH);
    localparam int TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef struct packed {
        logic                   write;
        logic [TAG_WIDTH-1:0]   tag;
        logic [INDEX_WIDTH-1:0] index;
        logic [DATA_WIDTH-1:0]  wdata;
    } cmd_t;

    state_e                  state_q, state_d;
    cmd_t                    cmd_q, cmd_d;
    logic                    hit_q, hit_d;
    logic                    err_q, err_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [TMR_W-1:0]        tmr_q, tmr_d;
    logic [COUNT_WIDTH-1:0]  hit_cnt_q, hit_cnt_d;
    logic [COUNT_WIDTH-1:0]  miss_cnt_q, miss_cnt_d;

    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    fifo_pop;
    logic [CW-1:0]           fifo_rdata;

    assign fifo_pop  = (state_q == ST_IDLE) && !fifo_empty;
    assign cmd_ready = !fifo_full;

    cache_cmd_fifo #(
        .WIDTH (CW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (cmd_valid),
        .push_data ({cmd_write, cmd_tag, cmd_index, cmd_wdata}),
        .pop       (fifo_pop),
        .pop_data  (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        hit_d       = hit_q;
        err_d       = err_q;
        rdata_d     = rdata_q;
        tmr_d       = tmr_q;
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        cache_read  = 1'b0;
        cache_write = 1'b0;
        rsp_valid   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (fifo_pop) begin
                    cmd_d   = cmd_t'(fifo_rdata);
                    hit_d   = 1'b0;
                    err_d   = 1'b0;
                    rdata_d = '0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cache_write = cmd_q.write;
                cache_read  = !cmd_q.write;
                state_d     = ST_HOLD;
            end
            ST_HOLD: begin
                cache_write = cmd_q.write;
                cache_read  = !cmd_q.write;
                hit_d       = cache_hit && !cmd_q.write;
                tmr_d       = TMR_W'(TIMEOUT - 1);
                state_d     = ST_WAIT;
            end
            ST_WAIT: begin
                // Counters move on entry to RESP so they already reflect the response on display.
                if (cache_ready) begin
                    if (!cmd_q.write) begin
                        rdata_d = read_data;
                        if (hit_q) hit_cnt_d  = sat_inc(hit_cnt_q);
                        else       miss_cnt_d = sat_inc(miss_cnt_q);
                    end
                    state_d = ST_RESP;
                end else if (tmr_q == '0) begin
                    err_d   = 1'b1;
                    hit_d   = 1'b0;
                    state_d = ST_RESP;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cmd_q      <= '0;
            hit_q      <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            tmr_q      <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            hit_q      <= hit_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            tmr_q      <= tmr_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign addr_tag   = cmd_q.tag;
    assign addr_index = cmd_q.index;
    assign write_data = cmd_q.wdata;
    assign rsp_write  = cmd_q.write;
    assign rsp_data   = rdata_q;
    assign rsp_hit    = hit_q;
    assign rsp_error  = err_q;
    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;

endmodule

// File: tb/tb_cache_req_master.sv
// Randomized scoreboard bench for cache_req_master with a behavioural direct-mapped
// cache device and an in-order reference model of expected responses.
module tb_cache_req_master;

    localparam int DW = 32;
    localparam int TW = 8;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [TW-1:0] cmd_tag = '0;
    logic [5:0]    cmd_index = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic          rsp_write;
    logic [DW-1:0] rsp_data;
    logic          rsp_hit;
    logic          rsp_error;
    logic [TW-1:0] addr_tag;
    logic [5:0]    addr_index;
    logic [DW-1:0] write_data;
    logic          cache_read;
    logic          cache_write;
    logic [DW-1:0] read_data = '0;
    logic          cache_hit;
    logic          cache_ready = 1'b0;
    logic [15:0]   hit_count;
    logic [15:0]   miss_count;

    cache_req_master #(
        .DATA_WIDTH (DW),
        .TAG_WIDTH  (TW),
        .FIFO_DEPTH (4),
        .TIMEOUT    (TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_tag     (cmd_tag),
        .cmd_index   (cmd_index),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_write   (rsp_write),
        .rsp_data    (rsp_data),
        .rsp_hit     (rsp_hit),
        .rsp_error   (rsp_error),
        .addr_tag    (addr_tag),
        .addr_index  (addr_index),
        .write_data  (write_data),
        .cache_read  (cache_read),
        .cache_write (cache_write),
        .read_data   (read_data),
        .cache_hit   (cache_hit),
        .cache_ready (cache_ready),
        .hit_count   (hit_count),
        .miss_count  (miss_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Cache device: lines written on the ready of a write; reads return line data on hit, else 0.
    logic          dev_v [64];
    logic [TW-1:0] dev_t [64];
    logic [DW-1:0] dev_d [64];
    int            dev_mode = 0;   // 0 answers after 2..6 cycles, 1 never answers
    bit            stray_en = 0;
    bit            dev_busy = 0;
    bit            strobe_prev = 0;
    int            dev_cd = 0;
    logic          l_wr, l_hit;
    logic [TW-1:0] l_tag;
    logic [5:0]    l_idx;
    logic [DW-1:0] l_wdat;
    int            t0 = 0;
    int            exp_lat = 0;

    assign cache_hit = (cache_read || cache_write) && dev_v[addr_index] && (dev_t[addr_index] == addr_tag);

    initial forever begin
        @(negedge clk);
        cache_ready = 1'b0;
        if (!rst_n) begin
            dev_busy    = 0;
            strobe_prev = 0;
        end else begin
            if (dev_busy) begin
                dev_cd--;
                if (dev_cd == 0) begin
                    cache_ready = 1'b1;
                    dev_busy    = 0;
                    if (l_wr) begin
                        dev_v[l_idx] = 1'b1;
                        dev_t[l_idx] = l_tag;
                        dev_d[l_idx] = l_wdat;
                    end else begin
                        read_data = l_hit ? dev_d[l_idx] : '0;
                    end
                end
            end else if ((cache_read || cache_write) && !strobe_prev) begin
                l_wr  = cache_write;
                l_tag = addr_tag;
                l_idx = addr_index;
                l_wdat = write_data;
                l_hit = cache_hit;
                t0    = cyc;
                if (dev_mode == 1) begin
                    exp_lat = TO + 2;
                end else begin
                    dev_cd   = $urandom_range(2, 6);
                    exp_lat  = dev_cd + 1;
                    dev_busy = 1;
                end
            end else if (stray_en && !(cache_read || cache_write) && $urandom_range(0, 7) == 0) begin
                cache_ready = 1'b1;
                read_data   = $urandom;
            end
            strobe_prev = cache_read || cache_write;
        end
    end

    int rr_mode = 1;   // 0 hold low, 1 always ready, 2 random
    initial forever begin
        @(posedge clk);
        #1;
        rsp_ready = (rr_mode == 1) || (rr_mode == 2 && $urandom_range(0, 2) != 0);
    end

    // Reference model: expected responses computed in command order from plain arrays.
    typedef struct packed {
        logic          w;
        logic [DW-1:0] data;
        logic          hit;
        logic          err;
    } exp_t;

    exp_t          sb[$];
    logic          ref_v [64];
    logic [TW-1:0] ref_t [64];
    logic [DW-1:0] ref_d [64];
    logic [15:0]   mh = '0;
    logic [15:0]   mm = '0;

    task automatic send(input logic w, input logic [TW-1:0] t, input logic [5:0] i, input logic [DW-1:0] d);
        exp_t e;
        int   k;
        logic h;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_tag   = t;
        cmd_index = i;
        cmd_wdata = d;
        k = 0;
        while (!cmd_ready && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (k >= 300) begin
            check("cmd_accept_timeout", 64'd0, 64'd1);
            cmd_valid = 1'b0;
            return;
        end
        if (dev_mode == 1) begin
            e = '{w: w, data: '0, hit: 1'b0, err: 1'b1};
        end else if (w) begin
            e = '{w: 1'b1, data: '0, hit: 1'b0, err: 1'b0};
            ref_v[i] = 1'b1;
            ref_t[i] = t;
            ref_d[i] = d;
        end else begin
            h = ref_v[i] && (ref_t[i] == t);
            e = '{w: 1'b0, data: (h ? ref_d[i] : '0), hit: h, err: 1'b0};
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 3000) check("drain_timeout", 64'(sb.size()), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    // Monitor: strobe width, latency, and in-order response comparison.
    bit prev_v = 0;
    int run = 0;
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!rst_n) begin
            prev_v = 0;
            run    = 0;
        end else begin
            if (cache_read && cache_write) check("strobe_exclusive", 64'd1, 64'd0);
            if (cache_read || cache_write) run++;
            else if (run > 0) begin
                check("strobe_len", 64'(run), 64'd2);
                run = 0;
            end
            if (rsp_valid && !prev_v) check("rsp_latency", 64'(cyc - t0), 64'(exp_lat));
            prev_v = rsp_valid;
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_rsp", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    if (!e.w && !e.err) begin
                        if (e.hit) mh = (mh == 16'hFFFF) ? mh : mh + 16'd1;
                        else       mm = (mm == 16'hFFFF) ? mm : mm + 16'd1;
                    end
                    check("rsp_write", 64'(rsp_write), 64'(e.w));
                    check("rsp_data",  64'(rsp_data),  64'(e.data));
                    check("rsp_hit",   64'(rsp_hit),   64'(e.hit));
                    check("rsp_error", 64'(rsp_error), 64'(e.err));
                    check("hit_count", 64'(hit_count), 64'(mh));
                    check("miss_count", 64'(miss_count), 64'(mm));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int seen;
        for (int i = 0; i < 64; i++) begin
            dev_v[i] = 1'b0; dev_t[i] = '0; dev_d[i] = '0;
            ref_v[i] = 1'b0; ref_t[i] = '0; ref_d[i] = '0;
        end
        repeat (3) @(negedge clk);
        check("rst_cmd_ready",  64'(cmd_ready),   64'd1);
        check("rst_rsp_valid",  64'(rsp_valid),   64'd0);
        check("rst_cache_read", 64'(cache_read),  64'd0);
        check("rst_cache_write", 64'(cache_write), 64'd0);
        check("rst_counts",     64'({hit_count, miss_count}), 64'd0);
        check("rst_outputs",    64'({addr_tag, addr_index, rsp_data}), 64'd0);
        rst_n = 1'b1;

        // Write then read of the same line, then a read miss.
        send(1'b1, 8'h3C, 6'd5, 32'h1234_5678);
        send(1'b0, 8'h3C, 6'd5, '0);
        drain();
        check("t1_hit_count", 64'(hit_count), 64'd1);
        send(1'b0, 8'h11, 6'd9, '0);
        drain();
        check("t2_miss_count", 64'(miss_count), 64'd1);

        // Five back-to-back commands with the response channel stalled.
        rr_mode = 0;
        for (int i = 0; i < 5; i++) send(1'(i % 2), 8'(i), 6'(i + 30), $urandom);
        @(negedge clk);
        check("fifo_full_cmd_ready", 64'(cmd_ready), 64'd0);
        repeat (10) @(negedge clk);
        check("fifo_still_full", 64'(cmd_ready), 64'd0);
        rr_mode = 1;
        drain();

        // Timeout on a line that would hit and on a write.
        dev_mode = 1;
        send(1'b0, 8'h3C, 6'd5, '0);
        send(1'b1, 8'h77, 6'd6, 32'hDEAD_BEEF);
        drain();
        check("to_counts", 64'({hit_count, miss_count}), 64'({mh, mm}));

        // Reset during WAIT with further commands queued.
        send(1'b0, 8'h01, 6'd1, '0);
        send(1'b0, 8'h02, 6'd2, '0);
        send(1'b0, 8'h03, 6'd3, '0);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rstw_strobes",   64'({cache_read, cache_write}), 64'd0);
        check("rstw_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rstw_rsp_valid", 64'(rsp_valid), 64'd0);
        sb.delete();
        mh = '0;
        mm = '0;
        dev_mode = 0;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (cache_read || cache_write || rsp_valid) seen++;
        end
        check("rstw_fifo_empty", 64'(seen), 64'd0);
        check("rstw_counts", 64'({hit_count, miss_count}), 64'd0);

        // Reset while a strobe is high must drop it immediately.
        send(1'b0, 8'h3C, 6'd5, '0);
        k = 0;
        while (!cache_read && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("rsth_saw_strobe", 64'(cache_read), 64'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rsth_strobes", 64'({cache_read, cache_write}), 64'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;

        // Hit counter saturation.
        send(1'b1, 8'h5A, 6'd20, 32'hCAFE_F00D);
        drain();
        @(negedge clk);
        force dut.hit_cnt_q = 16'hFFFE;
        mh = 16'hFFFE;
        @(negedge clk);
        release dut.hit_cnt_q;
        @(negedge clk);
        check("sat_preload", 64'(hit_count), 64'hFFFE);
        for (int i = 0; i < 3; i++) send(1'b0, 8'h5A, 6'd20, '0);
        drain();
        check("sat_hit_count", 64'(hit_count), 64'hFFFF);

        // Randomized traffic with backpressure and stray ready pulses.
        rr_mode  = 2;
        stray_en = 1;
        for (int i = 0; i < 80; i++) begin
            send(1'($urandom_range(0, 1)), 8'($urandom_range(0, 3)), 6'($urandom_range(0, 7)), $urandom);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 8)) @(negedge clk);
        end
        drain();
        stray_en = 0;
        check("final_counts", 64'({hit_count, miss_count}), 64'({mh, mm}));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cache_req_master.md
Name: cache_req_master

Overview:
- Initiator for the cache host's read/write request interface.
- Buffers commands from upstream logic in a small FIFO.
- Sequences each command onto cache_read/cache_write with the timing the cache FSM requires (IDLE, ACCESS, COMPLETE), captures read_data and the hit flag, and returns one response per command over a valid/ready channel.
- Adds a response timeout and saturating hit/miss counters for test and debug.

Parameters:
- DATA_WIDTH, 32, cache data width
- TAG_WIDTH, 8, cache tag width
- FIFO_DEPTH, 4, command FIFO entries (power of two, >=2)
- TIMEOUT, 16, cycles allowed in WAIT for cache_ready before abort

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO not full
- cmd_write  in  1  1 = write, 0 = read
- cmd_tag  in  TAG_WIDTH  tag
- cmd_index  in  6  line index
- cmd_wdata  in  DATA_WIDTH  write data
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_write  out  1  echo of cmd_write
- rsp_data  out  DATA_WIDTH  read data; 0 for writes and errors
- rsp_hit  out  1  hit flag sampled during ACCESS; 0 for writes and errors
- rsp_error  out  1  timeout abort
- addr_tag  out  TAG_WIDTH  to cache
- addr_index  out  6  to cache
- write_data  out  DATA_WIDTH  to cache
- cache_read  out  1  to cache
- cache_write  out  1  to cache
- read_data  in  DATA_WIDTH  from cache
- cache_hit  in  1  from cache (combinational)
- cache_ready  in  1  from cache (one-cycle pulse)
- hit_count  out  16  saturating read-hit count
- miss_count  out  16  saturating read-miss count

Behaviour:
- Reset (rst_n low, asynchronous):
  - FSM to IDLE; FIFO emptied.
  - All outputs 0, except cmd_ready, which is 1.
  - Counters cleared.
  - A reset mid-transaction drops the in-flight command with no response.
- Command FIFO:
  - Push when cmd_valid && cmd_ready.
  - cmd_ready = !full.
  - A simultaneous push and pop when full is not allowed; cmd_ready is low when full.
  - Pop occurs on the IDLE->ISSUE transition.
- FSM states: IDLE, ISSUE, HOLD, WAIT, RESP.
  - IDLE: if FIFO not empty, pop the head into the command register and go to ISSUE. addr_tag, addr_index and write_data are driven from the command register until the next pop. No request strobe is asserted in IDLE.
  - ISSUE (1 cycle): assert cache_write=cmd_write and cache_read=!cmd_write. Next state is HOLD.
  - HOLD (1 cycle): keep the same strobe asserted. Register cache_hit into hit_q. Next state is WAIT.
  - WAIT: both strobes are 0.
    - On cache_ready=1: capture read_data (reads only) and go to RESP.
    - A timeout counter starts at 0 on entry. If it reaches TIMEOUT-1 without cache_ready, set rsp_error=1 and go to RESP.
  - RESP: rsp_valid=1, with rsp_* held stable until rsp_ready. On rsp_valid && rsp_ready, go to IDLE; the next command may pop in the following cycle.
- Strobe timing: the strobe is deasserted before cache_ready arrives. This stops the cache from sampling a stale request when it re-enters IDLE.
- Latency from pop to rsp_valid, for a cache returning ready 3 cycles after the first strobe: 5 cycles.
- Responses come back in command order. At most one command is outstanding.
- Counters:
  - On a read response without error, increment hit_count if hit_q, else miss_count.
  - Counters saturate at 16'hFFFF.
  - Writes and errors are not counted.
- A cache_ready arriving outside WAIT is ignored.

Decomposition:
- Package cache_req_pkg:
  - FSM state enum (3-bit)
  - cmd record width constant (1+TAG_WIDTH+6+DATA_WIDTH)
  - INDEX_WIDTH=6
  - COUNT_WIDTH=16
- Sub-module cache_cmd_fifo: synchronous FIFO with parameterized width/depth and full/empty flags, reset by rst_n.

Test Plan:
- Write then read, same line:
  - Stimulus: write tag 8'h3C, index 5, data 32'h1234_5678; then a read of the same tag and index.
  - Required: write response rsp_write=1, rsp_data=0. Read response rsp_hit=1, rsp_data equals the cache's read_data. hit_count=1.
- Read miss:
  - Stimulus: read tag 8'h11, index 9 on an empty cache.
  - Required: rsp_hit=0, rsp_data=0, miss_count=1. cache_read high for exactly 2 cycles.
- FIFO full:
  - Stimulus: push 5 commands back-to-back with rsp_ready=0.
  - Required: cmd_ready drops after the 4th buffered entry (one command is in flight). All 5 responses return in order once rsp_ready=1.
- Timeout:
  - Stimulus: tie cache_ready=0.
  - Required: rsp_error=1 exactly TIMEOUT cycles after WAIT entry. rsp_data=0, rsp_hit=0, counters unchanged.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 during WAIT.
  - Required: all strobes go to 0 immediately (asynchronously), FIFO is empty, cmd_ready=1, rsp_valid=0.
- Counter saturation:
  - Stimulus: force hit_count to 16'hFFFE and issue 3 read hits.
  - Required: hit_count=16'hFFFF.
